apb4_crc_stream: RTL and testbench

APB4-attached streaming CRC engine, successor to the fixed-polynomial CRC peripheral. It generalises that peripheral with:
- a runtime-programmable polynomial and width (8/16/32);
- a parametrised input FIFO, so one multi-word message accumulates across many writes;
- a one-byte-per-cycle engine with busy/overflow status and a completion interrupt.

It sits on the peripheral APB4 bus alongside the other `apb4_*` blocks.

---
 rtl/apb4_crc_stream_if.sv | 27 ++
 rtl/apb4_crc_stream.sv | 189 ++++++++++++++++++
 tb/tb_apb4_crc_stream.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb4_crc_stream_if.sv
// APB4 bus bundle shared by the apb4_* peripherals.
//   pclk/presetn      : clock, asynchronous active-low reset
//   paddr/pwdata      : address and write data (master -> slave)
//   psel/penable/pwrite: transfer control (master -> slave)
//   prdata/pready/pslverr: read data and response (slave -> master)
interface apb4_if;
  logic        pclk;
  logic        presetn;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport slave (
    input  pclk, presetn, paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  pclk, presetn, prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_crc_stream.sv
// Streaming CRC engine on APB4: programmable polynomial/width (8/16/32),
// input word FIFO, one byte per cycle, busy/overflow status, done interrupt.
//   apb4  : APB4 slave port (clock, reset, register access)
//   irq_o : level interrupt, CTRL.ie & STAT.done
module apb4_crc_stream #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  apb4_if.slave apb4,
  output logic  irq_o
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W  = 34;
  localparam logic [31:0] POLY_RST = 32'h04C1_1DB7;

  // Processing aligns the CRC to bit 31 so one datapath serves all widths.
  function automatic logic [4:0] align_sh(input logic [1:0] crcw);
    case (crcw)
      2'd0:    return 5'd24;
      2'd1:    return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b,
                                           input logic [31:0] poly, input logic [4:0] sh);
    logic [31:0] c;
    logic [31:0] p;
    c = (crc << sh) ^ {b, 24'h0};
    p = poly << sh;
    for (int i = 0; i < 8; i++) c = c[31] ? ((c << 1) ^ p) : (c << 1);
    return c >> sh;
  endfunction

  logic               en_q, en_d, revin_q, revin_d, revout_q, revout_d, ie_q, ie_d;
  logic [1:0]         crcw_q, crcw_d, size_q, size_d;
  logic [31:0]        init_q, init_d, xorv_q, xorv_d, poly_q, poly_d, crc_q, crc_d;
  logic               ovf_q, ovf_d, done_q, done_d, irq_q;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        word_q, word_d;
  logic [2:0]         left_q, left_d;

  logic               wr_hs_c, rd_hs_c, clr_c, push_c, push_ok_c, pop_c, retire_c, last_c;
  logic               busy_c, empty_c, full_c;
  logic [3:0]         idx_c;
  logic [ENTRY_W-1:0] head_c;
  logic [7:0]         byte_c;
  logic [31:0]        mask_c, crc_m_c, res_c;
  logic               unused_c;

  assign wr_hs_c   = apb4.psel & apb4.penable & apb4.pwrite;
  assign rd_hs_c   = apb4.psel & apb4.penable & ~apb4.pwrite;
  assign idx_c     = apb4.paddr[5:2];
  assign unused_c  = ^{apb4.paddr[31:6], apb4.paddr[1:0]};
  assign clr_c     = wr_hs_c & (idx_c == 4'd0) & apb4.pwdata[8];
  assign push_c    = wr_hs_c & (idx_c == 4'd4);
  assign empty_c   = (count_q == '0);
  assign full_c    = (count_q == CNT_W'(FIFO_DEPTH));
  assign push_ok_c = push_c & ~full_c;
  assign busy_c    = (left_q != 3'd0);
  assign last_c    = (left_q == 3'd1);
  assign retire_c  = en_q & busy_c;
  // Pop on the last byte too, so back-to-back words leave no bubble.
  assign pop_c     = en_q & ~empty_c & (~busy_c | last_c) & ~clr_c;
  assign head_c    = mem_q[rd_ptr_q];
  assign byte_c    = revin_q ? rev8(word_q[31:24]) : word_q[31:24];
  assign mask_c    = 32'hFFFF_FFFF >> align_sh(crcw_q);
  assign crc_m_c   = crc_q & mask_c;
  assign res_c     = ((revout_q ? (rev32(crc_m_c) >> align_sh(crcw_q)) : crc_m_c) ^ xorv_q) & mask_c;

  // Next-state: register writes, FIFO, engine, then clr overrides.
  always_comb begin
    en_d = en_q; revin_d = revin_q; revout_d = revout_q; ie_d = ie_q;
    crcw_d = crcw_q; size_d = size_q;
    init_d = init_q; xorv_d = xorv_q; poly_d = poly_q; crc_d = crc_q;
    ovf_d = ovf_q; done_d = done_q;
    mem_d = mem_q; wr_ptr_d = wr_ptr_q; rd_ptr_d = rd_ptr_q; count_d = count_q;
    word_d = word_q; left_d = left_q;

    if (wr_hs_c) begin
      case (idx_c)
        4'd0: begin
          en_d     = apb4.pwdata[0];
          revin_d  = apb4.pwdata[1];
          revout_d = apb4.pwdata[2];
          crcw_d   = apb4.pwdata[4:3];
          size_d   = apb4.pwdata[6:5];
          ie_d     = apb4.pwdata[7];
        end
        4'd1: init_d = apb4.pwdata;
        4'd2: xorv_d = apb4.pwdata;
        4'd3: poly_d = apb4.pwdata;
        4'd6: begin
          if (apb4.pwdata[3]) ovf_d = 1'b0;
          if (apb4.pwdata[4]) done_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (push_c && full_c) ovf_d = 1'b1;
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = {size_q, apb4.pwdata};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok_c && !pop_c) count_d = count_q + CNT_W'(1);
    else if (!push_ok_c && pop_c) count_d = count_q - CNT_W'(1);

    if (retire_c) begin
      crc_d  = crc_step(crc_q, byte_c, poly_q, align_sh(crcw_q));
      word_d = word_q << 8;
      left_d = left_q - 3'd1;
      if (last_c && !pop_c) done_d = 1'b1;
    end
    // Left-justify the valid bytes so the first one sits in [31:24].
    if (pop_c) begin
      word_d = head_c[31:0] << {~head_c[33:32], 3'b000};
      left_d = {1'b0, head_c[33:32]} + 3'd1;
    end

    if (clr_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      left_d   = 3'd0;
      crc_d    = init_q & (32'hFFFF_FFFF >> align_sh(apb4.pwdata[4:3]));
      done_d   = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge apb4.pclk or negedge apb4.presetn) begin
    if (!apb4.presetn) begin
      en_q <= 1'b0; revin_q <= 1'b0; revout_q <= 1'b0; ie_q <= 1'b0;
      crcw_q <= 2'd0; size_q <= 2'd0;
      init_q <= '0; xorv_q <= '0; poly_q <= POLY_RST; crc_q <= '0;
      ovf_q <= 1'b0; done_q <= 1'b0; irq_q <= 1'b0;
      mem_q <= '{default: '0};
      wr_ptr_q <= '0; rd_ptr_q <= '0; count_q <= '0;
      word_q <= '0; left_q <= 3'd0;
    end else begin
      en_q <= en_d; revin_q <= revin_d; revout_q <= revout_d; ie_q <= ie_d;
      crcw_q <= crcw_d; size_q <= size_d;
      init_q <= init_d; xorv_q <= xorv_d; poly_q <= poly_d; crc_q <= crc_d;
      ovf_q <= ovf_d; done_q <= done_d; irq_q <= ie_d & done_d;
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d;
      word_q <= word_d; left_q <= left_d;
    end
  end

  // APB read data is combinational within the access phase.
  always_comb begin
    apb4.prdata = 32'h0;
    if (rd_hs_c) begin
      case (idx_c)
        4'd0: apb4.prdata = {24'h0, ie_q, size_q, crcw_q, revout_q, revin_q, en_q};
        4'd1: apb4.prdata = init_q;
        4'd2: apb4.prdata = xorv_q;
        4'd3: apb4.prdata = poly_q;
        4'd5: apb4.prdata = res_c;
        4'd6: apb4.prdata = {16'h0, 8'(count_q), 3'b000, done_q, ovf_q, full_c, empty_c, busy_c};
        default: apb4.prdata = 32'h0;
      endcase
    end
  end

  assign apb4.pready  = 1'b1;
  assign apb4.pslverr = 1'b0;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_apb4_crc_stream.sv
// Directed bench for apb4_crc_stream: scoreboard of expected RES values,
// reference CRC model computed bit-serially, register/status/timing checks.
module tb_apb4_crc_stream;

  localparam logic [31:0] A_CTRL = 32'h00, A_INIT = 32'h04, A_XORV = 32'h08, A_POLY = 32'h0C;
  localparam logic [31:0] A_DATA = 32'h10, A_RES  = 32'h14, A_STAT = 32'h18;

  logic clk;
  logic rst_n;
  logic irq;

  apb4_if bus ();
  assign bus.pclk    = clk;
  assign bus.presetn = rst_n;

  apb4_crc_stream #(.FIFO_DEPTH(8)) dut (
    .apb4  (bus),
    .irq_o (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] rd;

  // Reference model state
  logic [31:0] m_crc, m_poly, m_xorv;
  int          m_w;
  bit          m_revin, m_revout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = addr; bus.pwdata = data;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = addr;
    @(negedge clk);
    bus.penable = 1'b1;
    #1 data = bus.prdata;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    apb_read(addr, v);
    check(tag, v, exp);
  endtask

  task automatic res_check(input string tag);
    logic [31:0] v;
    logic [31:0] e;
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    apb_read(A_RES, v);
    check(tag, v, e);
  endtask

  task automatic wait_irq(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && irq !== 1'b1; i++) @(negedge clk);
    check(tag, {31'h0, irq}, 32'h1);
  endtask

  function automatic logic [31:0] ctrl(bit en, bit ri, bit ro, logic [1:0] w, logic [1:0] sz, bit ie, bit clr);
    return {23'h0, clr, ie, sz, w, ro, ri, en};
  endfunction

  function automatic logic [31:0] wmask(int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  // Bit-serial feedback form of the CRC, one message bit at a time.
  task automatic m_push(input logic [31:0] data, input int size);
    logic [7:0] b;
    logic       fb;
    for (int j = size; j >= 0; j--) begin
      b = data[8*j +: 8];
      for (int k = 7; k >= 0; k--) begin
        fb    = m_crc[m_w-1] ^ (m_revin ? b[7-k] : b[k]);
        m_crc = (m_crc << 1) & wmask(m_w);
        if (fb) m_crc = m_crc ^ (m_poly & wmask(m_w));
      end
    end
  endtask

  function automatic logic [31:0] m_result();
    logic [31:0] r;
    r = '0;
    if (m_revout) for (int i = 0; i < m_w; i++) r[i] = m_crc[m_w-1-i];
    else r = m_crc;
    return (r ^ m_xorv) & wmask(m_w);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    tick(3);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_prdata", bus.prdata, 32'h0);
    rst_n = 1'b1;
    tick(1);

    // Setup phase (penable low) must not drive read data.
    bus.psel = 1'b1; bus.paddr = A_POLY; bus.pwrite = 1'b0;
    #1 check("setup_prdata", bus.prdata, 32'h0);
    tick(1);
    bus.psel = 1'b0;

    read_check("rst_poly", A_POLY, 32'h04C1_1DB7);
    read_check("rst_ctrl", A_CTRL, 32'h0);
    read_check("rst_stat", A_STAT, 32'h0000_0002);
    read_check("rst_res", A_RES, 32'h0);
    read_check("unmapped7", 32'h1C, 32'h0);
    read_check("unmapped15", 32'h3C, 32'h0);

    // CRC-8, single byte, exact latency
    apb_write(A_POLY, 32'h07);
    apb_write(A_INIT, 32'h0);
    apb_write(A_XORV, 32'h0);
    apb_write(A_CTRL, ctrl(1, 0, 0, 2'd0, 2'd0, 1, 1));
    read_check("crc8_ctrl_clr0", A_CTRL, 32'h81);
    exp_q.push_back(32'h07);
    apb_write(A_DATA, 32'h01);
    check("crc8_irq_k", {31'h0, irq}, 32'h0);
    read_check("crc8_stat_k1", A_STAT, 32'h0000_0003);
    check("crc8_irq_k2", {31'h0, irq}, 32'h1);
    read_check("crc8_stat_done", A_STAT, 32'h0000_0012);
    res_check("crc8_res");
    read_check("data_reads0", A_DATA, 32'h0);

    // CRC-16/CCITT-FALSE over "123456789"
    apb_write(A_POLY, 32'h1021);
    apb_write(A_INIT, 32'hFFFF);
    apb_write(A_CTRL, ctrl(1, 0, 0, 2'd1, 2'd0, 1, 1));
    exp_q.push_back(32'h29B1);
    for (int i = 0; i < 9; i++) apb_write(A_DATA, 32'h31 + i);
    tick(4);
    res_check("crc16_res");
    read_check("crc16_stat_done", A_STAT, 32'h0000_0012);
    apb_write(A_STAT, 32'h10);
    read_check("crc16_stat_w1c", A_STAT, 32'h0000_0002);
    check("crc16_irq_cleared", {31'h0, irq}, 32'h0);

    // CRC-32 reflected, mixed word sizes, continuous 1 byte/cycle
    apb_write(A_POLY, 32'h04C1_1DB7);
    apb_write(A_INIT, 32'hFFFF_FFFF);
    apb_write(A_XORV, 32'hFFFF_FFFF);
    apb_write(A_CTRL, ctrl(0, 1, 1, 2'd2, 2'd3, 1, 1));
    exp_q.push_back(32'hCBF4_3926);
    apb_write(A_DATA, 32'h3132_3334);
    apb_write(A_DATA, 32'h3536_3738);
    apb_write(A_CTRL, ctrl(0, 1, 1, 2'd2, 2'd0, 1, 0));
    apb_write(A_DATA, 32'h0000_0039);
    read_check("crc32_stat_held", A_STAT, 32'h0000_0300);
    apb_write(A_CTRL, ctrl(1, 1, 1, 2'd2, 2'd0, 1, 0));
    read_check("crc32_stat_k1", A_STAT, 32'h0000_0201);
    tick(7);
    check("crc32_irq_k9", {31'h0, irq}, 32'h0);
    tick(1);
    check("crc32_irq_k10", {31'h0, irq}, 32'h1);
    res_check("crc32_res");

    // CRC-16/0x8005 with revin, partial-width words, model-derived result
    m_w = 16; m_poly = 32'h8005; m_xorv = 32'h1234; m_revin = 1; m_revout = 0;
    m_crc = 32'hBEEF;
    apb_write(A_POLY, 32'h8005);
    apb_write(A_INIT, 32'hBEEF);
    apb_write(A_XORV, 32'h1234);
    apb_write(A_CTRL, ctrl(1, 1, 0, 2'd1, 2'd1, 0, 1));
    apb_write(A_DATA, 32'hDEAD_A55A);   m_push(32'hDEAD_A55A, 1);
    apb_write(A_CTRL, ctrl(1, 1, 0, 2'd1, 2'd2, 0, 0));
    apb_write(A_DATA, 32'h00C0_FFEE);   m_push(32'h00C0_FFEE, 2);
    apb_write(A_CTRL, ctrl(1, 1, 0, 2'd1, 2'd3, 0, 0));
    apb_write(A_DATA, 32'h1234_5678);   m_push(32'h1234_5678, 3);
    exp_q.push_back(m_result());
    tick(8);
    read_check("model_stat_done", A_STAT, 32'h0000_0012);
    check("model_irq_ie0", {31'h0, irq}, 32'h0);
    res_check("model_res");

    // Overflow with engine disabled
    apb_write(A_CTRL, ctrl(0, 0, 0, 2'd2, 2'd3, 0, 1));
    for (int i = 0; i < 9; i++) apb_write(A_DATA, 32'hA000_0000 + i);
    read_check("ovf_stat", A_STAT, 32'h0000_080C);
    apb_write(A_STAT, 32'h08);
    read_check("ovf_w1c", A_STAT, 32'h0000_0804);

    // Abort a running CRC-32 stream with clr
    apb_write(A_POLY, 32'h04C1_1DB7);
    apb_write(A_INIT, 32'h1234_5678);
    apb_write(A_XORV, 32'hFFFF_FFFF);
    apb_write(A_CTRL, ctrl(1, 0, 0, 2'd2, 2'd3, 0, 1));
    for (int i = 0; i < 4; i++) apb_write(A_DATA, 32'h0102_0304 * (i + 1));
    apb_read(A_STAT, rd);
    check("abort_busy_before", {31'h0, rd[0]}, 32'h1);
    exp_q.push_back(32'hEDCB_A987);
    apb_write(A_CTRL, ctrl(1, 0, 0, 2'd2, 2'd3, 0, 1));
    read_check("abort_stat_after", A_STAT, 32'h0000_0002);
    res_check("abort_res");

    // Asynchronous reset in the middle of a stream
    apb_write(A_POLY, 32'h07);
    apb_write(A_CTRL, ctrl(1, 0, 0, 2'd2, 2'd3, 1, 0));
    apb_write(A_DATA, 32'hAABB_CCDD);
    wait_irq("midrst_irq_before", 10);
    apb_write(A_DATA, 32'h1122_3344);
    apb_write(A_DATA, 32'h5566_7788);
    rst_n = 1'b0;
    #1;
    check("midrst_irq", {31'h0, irq}, 32'h0);
    check("midrst_prdata", bus.prdata, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    read_check("midrst_poly", A_POLY, 32'h04C1_1DB7);
    read_check("midrst_ctrl", A_CTRL, 32'h0);
    read_check("midrst_init", A_INIT, 32'h0);
    read_check("midrst_xorv", A_XORV, 32'h0);
    read_check("midrst_stat", A_STAT, 32'h0000_0002);
    read_check("midrst_res", A_RES, 32'h0);
    check("scoreboard_drained", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
